nbin_repl_feeder: RTL and testbench
===================================

# nbin_repl_feeder

Transmit-side feeder for the zero-optimised NFU pipeline. It accepts input bricks (Tn lanes of BIT_WIDTH) from the NBin read port using a valid/ready handshake. It holds a lookahead window of D+1 bricks. For each issue it loads the D following bricks into the pipeline's replacement-candidate registers, one register per cycle, and then presents the current brick on the pipeline's input bus. It sits between the NBin SRAM controller and the pipeline top; its outputs drive that top's inputs, replacement-candidate and replacement-load-select ports directly.

## Interface
- BIT_WIDTH, 16, bits per lane
- Tn, 16, lanes per brick
- D, 3, replacement-candidate depth (number of lookahead bricks)
- REPL_LOAD_WIDTH, 2, width of load select; 2^REPL_LOAD_WIDTH must be at least D+1
- clk  input  1  main clock, all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- i_brick  input  BIT_WIDTH*Tn  brick from NBin, lane 0 in LSBs
- i_brick_valid  input  1  i_brick and i_last are valid
- i_last  input  1  marks the final brick of a layer pass
- o_brick_ready  output  1  feeder accepts a brick this cycle
- i_stall  input  1  downstream pipeline cannot advance
- o_inputs  output  BIT_WIDTH*Tn  current brick to the pipeline inputs
- o_issue  output  1  o_inputs is valid this cycle
- o_repl_cands  output  BIT_WIDTH*Tn  candidate brick being loaded
- o_sel_repl_load  output  REPL_LOAD_WIDTH  target candidate register; all-ones means no load
- o_zero_lanes  output  $clog2(Tn+1)  count of zero lanes in o_inputs, valid when o_issue is high
- o_done  output  1  one-cycle pulse after the last brick issues
- o_issued_count  output  16  number of issued bricks, wraps modulo 2^16

## Operation
- Window: slots W[0..D], each a BIT_WIDTH*Tn register, plus an occupancy counter cnt (0..D+1) and a last_seen flag.
- Acceptance:
  - A brick is accepted when i_brick_valid and o_brick_ready are both high.
  - It is written into W[cnt] and cnt increments.
  - If i_last is high on acceptance, last_seen is set.
- o_brick_ready = (cnt < D+1) && !last_seen && state is IDLE or FILL.
- States and transitions:
  - IDLE: cnt = 0. Go to FILL on the first acceptance.
  - FILL: collect bricks. Go to LOAD when cnt == D+1, or when last_seen && cnt >= 1.
  - LOAD: k steps 0..D-1, one step per unstalled cycle.
    - Drive o_sel_repl_load = k and o_repl_cands = W[k+1].
    - If slot k+1 is at or beyond cnt, o_repl_cands is all zeros (drain padding).
    - After k = D-1, go to ISSUE.
  - ISSUE: drive o_inputs = W[0] and o_issue = 1. On the unstalled cycle:
    - shift W[i] <= W[i+1] and clear W[D];
    - decrement cnt and increment o_issued_count;
    - next state:
      - cnt was 1 and last_seen set: go to IDLE, pulse o_done the following cycle, clear last_seen.
      - last_seen set, cnt was greater than 1: go to LOAD.
      - otherwise: go to FILL.
- Stall: while i_stall is high in LOAD or ISSUE:
  - the state, k and the window hold;
  - o_sel_repl_load is forced to all-ones;
  - o_issue is forced to 0.
- Outputs outside LOAD and ISSUE:
  - o_sel_repl_load is all-ones;
  - o_issue is 0;
  - o_inputs and o_repl_cands are zero.
- o_zero_lanes is a combinational popcount of lanes of W[0] equal to zero.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, cnt 0, last_seen 0, window zero. Output reset values:
  - o_brick_ready 1
  - o_issue 0
  - o_sel_repl_load all-ones
  - o_inputs and o_repl_cands 0
  - o_zero_lanes Tn (W[0] is all-zero)
  - o_done 0
  - o_issued_count 0
- Steady state (no stalls): D LOAD cycles, 1 ISSUE cycle and 1 FILL cycle per brick.
- First issue from reset: D+1 acceptance cycles, then D LOAD cycles, then ISSUE.
- Because o_brick_ready is low in LOAD and ISSUE, acceptance and shift never happen in the same cycle.
- Reset asserted mid-operation discards the window immediately; no o_done pulse is produced.
- i_stall has no effect in IDLE or FILL.

## Configuration
- ZERO_SKIP_EN defined:
  - In ISSUE, if every lane of W[0] is zero, o_issue stays 0.
  - The shift, cnt and state transition still occur, so the brick is dropped.
  - o_issued_count does not increment for a dropped brick.
  - The candidate loads already made for that slot are wasted.
- ZERO_SKIP_EN undefined: every brick is issued.

## Test plan
- Reset then 4 bricks B0..B3 (B0 lane0 = 0x0001, B1 = 0x0002, etc.), no last -> o_sel_repl_load 0,1,2 carries B1,B2,B3. ISSUE then shows o_inputs = B0 with o_issue = 1. o_issued_count = 1.
- Single brick with i_last = 1 -> 3 LOAD cycles with o_repl_cands = 0. Then ISSUE of the brick, o_done pulse, return to IDLE with cnt 0.
- Hold i_stall = 1 for 5 cycles during LOAD k = 1 -> o_sel_repl_load = all-ones throughout the stall. Loading resumes at k = 1; total issue is delayed by exactly 5 cycles.
- Brick with lanes 0..7 zero and lanes 8..15 = 0x00FF -> o_zero_lanes = 8 on issue.
- Apply i_brick_valid while the window is full -> o_brick_ready = 0, and no brick is lost or duplicated across 20 random bricks.
- ZERO_SKIP_EN defined: stream B0, Z (all-zero), B2, last -> only B0 and B2 issue. o_issued_count = 2 and o_done pulses once.

Source files
------------

// File: rtl/nbin_repl_feeder.sv
// Transmit-side feeder: buffers D+1 NBin bricks, loads D lookahead candidates, then issues the head brick.
// Optional ZERO_SKIP_EN: all-zero head bricks are dropped instead of issued.
module nbin_repl_feeder #(
    parameter int unsigned BIT_WIDTH       = 16,
    parameter int unsigned Tn              = 16,
    parameter int unsigned D               = 3,
    parameter int unsigned REPL_LOAD_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BIT_WIDTH*Tn-1:0]       i_brick,
    input  logic                          i_brick_valid,
    input  logic                          i_last,
    output logic                          o_brick_ready,
    input  logic                          i_stall,
    output logic [BIT_WIDTH*Tn-1:0]       o_inputs,
    output logic                          o_issue,
    output logic [BIT_WIDTH*Tn-1:0]       o_repl_cands,
    output logic [REPL_LOAD_WIDTH-1:0]    o_sel_repl_load,
    output logic [$clog2(Tn+1)-1:0]       o_zero_lanes,
    output logic                          o_done,
    output logic [15:0]                   o_issued_count
);
    localparam int unsigned BW = BIT_WIDTH * Tn;
    localparam int unsigned CW = $clog2(D + 2);
    localparam int unsigned ZW = $clog2(Tn + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_LOAD, S_ISSUE} state_t;

    state_t                     state, state_nxt;
    logic [BW-1:0]              win [0:D];
    logic [CW-1:0]              cnt, cnt_acc;
    logic                       last_seen, last_acc;
    logic [REPL_LOAD_WIDTH-1:0] k;
    logic                       done_q;
    logic [15:0]                issued;
    logic                       accept, shift;
    logic [ZW-1:0]              zl;

    assign o_brick_ready  = (cnt < CW'(D + 1)) && !last_seen &&
                            (state == S_IDLE || state == S_FILL);
    assign accept         = i_brick_valid && o_brick_ready;
    assign shift          = (state == S_ISSUE) && !i_stall;
    assign cnt_acc        = cnt + CW'(accept);
    assign last_acc       = last_seen || (accept && i_last);
    assign o_done         = done_q;
    assign o_issued_count = issued;
    assign o_zero_lanes   = zl;

    always_comb begin
        zl = '0;
        for (int unsigned i = 0; i < Tn; i++)
            if (win[0][i*BIT_WIDTH +: BIT_WIDTH] == '0) zl = zl + ZW'(1);
    end

    // FILL looks at the post-acceptance occupancy so steady state needs only one FILL cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_FILL;
            S_FILL:  if (cnt_acc == CW'(D + 1) || (last_acc && cnt_acc != '0))
                         state_nxt = S_LOAD;
            S_LOAD:  if (!i_stall && k == REPL_LOAD_WIDTH'(D - 1)) state_nxt = S_ISSUE;
            S_ISSUE: if (!i_stall) begin
                         if (last_seen && cnt == CW'(1)) state_nxt = S_IDLE;
                         else if (last_seen)             state_nxt = S_LOAD;
                         else                            state_nxt = S_FILL;
                     end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_sel_repl_load = '1;
        o_repl_cands    = '0;
        o_inputs        = '0;
        o_issue         = 1'b0;
        if (state == S_LOAD) begin
            if (!i_stall) o_sel_repl_load = k;
            for (int unsigned i = 1; i <= D; i++)
                if (i == 32'(k) + 1 && i < 32'(cnt)) o_repl_cands = win[i];
        end
        if (state == S_ISSUE) begin
            o_inputs = win[0];
`ifdef ZERO_SKIP_EN
            o_issue  = !i_stall && (zl != ZW'(Tn));
`else
            o_issue  = !i_stall;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_seen <= 1'b0;
            k         <= '0;
            done_q    <= 1'b0;
            issued    <= '0;
            for (int unsigned i = 0; i <= D; i++) win[i] <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            if (state != S_LOAD) k <= '0;
            else if (!i_stall)   k <= k + REPL_LOAD_WIDTH'(1);
            if (shift) begin
                for (int unsigned i = 0; i < D; i++) win[i] <= win[i+1];
                win[D] <= '0;
                cnt    <= cnt - CW'(1);
                if (last_seen && cnt == CW'(1)) begin
                    last_seen <= 1'b0;
                    done_q    <= 1'b1;
                end
            end else if (accept) begin
                for (int unsigned i = 0; i <= D; i++)
                    if (32'(cnt) == i) win[i] <= i_brick;
                cnt <= cnt + CW'(1);
                if (i_last) last_seen <= 1'b1;
            end
            if (o_issue) issued <= issued + 16'd1;
        end
    end
endmodule

// File: tb/tb_nbin_repl_feeder.sv
// Directed self-checking bench for nbin_repl_feeder (default parameters).
module tb_nbin_repl_feeder;
    localparam int unsigned BW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] brick = '0;
    logic          valid = 1'b0;
    logic          last = 1'b0;
    logic          stall = 1'b0;
    logic          ready, issue, done;
    logic [BW-1:0] inputs, cands;
    logic [1:0]    sel;
    logic [4:0]    zero_lanes;
    logic [15:0]   issued_count;

    int checks = 0;
    int failures = 0;
    logic [BW-1:0] tx_q[$];
    logic [BW-1:0] exp_q[$];

    nbin_repl_feeder #(.BIT_WIDTH(16), .Tn(16), .D(3), .REPL_LOAD_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_brick(brick), .i_brick_valid(valid), .i_last(last),
        .o_brick_ready(ready), .i_stall(stall), .o_inputs(inputs), .o_issue(issue),
        .o_repl_cands(cands), .o_sel_repl_load(sel), .o_zero_lanes(zero_lanes),
        .o_done(done), .o_issued_count(issued_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [BW-1:0] b, input logic l);
        int n = 0;
        brick = b; last = l; valid = 1'b1;
        while (!ready && n < 50) begin step(); n++; end
        check("send_ready", ready, 1'b1);
        step();
        valid = 1'b0; last = 1'b0;
    endtask

    // Streams tx_q (last on final entry) and compares every issued brick against exp_q.
    task automatic run_stream(input string tag, output int n_issue, output int n_done, output int n_full);
        int ti = 0;
        int cyc = 0;
        bit acc;
        bit seen = 0;
        n_issue = 0; n_done = 0; n_full = 0;
        while (cyc < 2000 && !seen) begin
            if (ti < tx_q.size()) begin
                valid = 1'b1; brick = tx_q[ti]; last = (ti == tx_q.size() - 1);
            end else begin
                valid = 1'b0; last = 1'b0;
            end
            if (issue) begin
                if (n_issue < exp_q.size()) check({tag, "_data"}, inputs, exp_q[n_issue]);
                n_issue++;
            end
            if (done) begin n_done++; seen = 1; end
            if (valid && !ready) n_full++;
            acc = valid && ready;
            step();
            cyc++;
            if (acc) ti++;
        end
        valid = 1'b0; last = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (!issue && n < 50) begin step(); n++; end
        check({tag, "_issue_seen"}, issue, 1'b1);
    endtask

    initial begin
        int ni, nd, nf, t;
        logic [15:0] base;
        logic [BW-1:0] r, zb;

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rst_ready", ready, 1'b1);
        check("rst_issue", issue, 1'b0);
        check("rst_sel", sel, 2'b11);
        check("rst_inputs", inputs, '0);
        check("rst_cands", cands, '0);
        check("rst_zero_lanes", zero_lanes, 5'd16);
        check("rst_done", done, 1'b0);
        check("rst_count", issued_count, 16'd0);

        // Four bricks, no last: candidates B1..B3 then issue B0
        for (int i = 1; i <= 4; i++) send(BW'(i), 1'b0);
        check("t1_sel0", sel, 2'd0);   check("t1_cand0", cands, BW'(2));
        step();
        check("t1_sel1", sel, 2'd1);   check("t1_cand1", cands, BW'(3));
        step();
        check("t1_sel2", sel, 2'd2);   check("t1_cand2", cands, BW'(4));
        step();
        check("t1_issue", issue, 1'b1);
        check("t1_inputs", inputs, BW'(1));
        check("t1_zl", zero_lanes, 5'd15);
        check("t1_ready_issue", ready, 1'b0);
        step();
        check("t1_count", issued_count, 16'd1);
        check("t1_issue_off", issue, 1'b0);
        check("t1_ready_fill", ready, 1'b1);
        tx_q = '{BW'(5)};
        exp_q = '{BW'(2), BW'(3), BW'(4), BW'(5)};
        run_stream("t1_drain", ni, nd, nf);
        check("t1_drain_n", ni, 4);
        check("t1_drain_done", nd, 1);
        check("t1_drain_count", issued_count, 16'd5);
        check("t1_done_pulse", done, 1'b0);

        // Single brick with last: padded candidates then issue and done
        r = {16{16'h1234}};
        send(r, 1'b1);
        check("t2_ready_last", ready, 1'b0);
        check("t2_sel_fill", sel, 2'b11);
        step();
        for (int k = 0; k < 3; k++) begin
            check("t2_sel", sel, BW'(k));
            check("t2_cand_pad", cands, '0);
            step();
        end
        check("t2_issue", issue, 1'b1);
        check("t2_inputs", inputs, r);
        check("t2_zl", zero_lanes, 5'd0);
        step();
        check("t2_done", done, 1'b1);
        check("t2_count", issued_count, 16'd6);
        check("t2_ready_idle", ready, 1'b1);
        step();
        check("t2_done_off", done, 1'b0);

        // Five-cycle stall at k=1
        for (int i = 0; i < 4; i++) send(BW'(16'h10 + i) | (BW'(16'hA0) << 240), 1'b0);
        t = 0;
        check("t3_sel0", sel, 2'd0);
        step(); t++;
        check("t3_sel1_pre", sel, 2'd1);
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1;
            #0;
            check("t3_stall_sel", sel, 2'b11);
            check("t3_stall_issue", issue, 1'b0);
            step(); t++;
        end
        stall = 1'b0;
        #0;
        check("t3_sel1_post", sel, 2'd1);
        check("t3_cand1_post", cands, BW'(16'h12) | (BW'(16'hA0) << 240));
        step(); t++;
        check("t3_sel2", sel, 2'd2);
        step(); t++;
        check("t3_issue", issue, 1'b1);
        check("t3_inputs", inputs, BW'(16'h10) | (BW'(16'hA0) << 240));
        check("t3_delay", t, 8);
        step();
        tx_q = '{BW'(16'h14)};
        exp_q = '{BW'(16'h11) | (BW'(16'hA0) << 240), BW'(16'h12) | (BW'(16'hA0) << 240),
                  BW'(16'h13) | (BW'(16'hA0) << 240), BW'(16'h14)};
        run_stream("t3_drain", ni, nd, nf);
        check("t3_drain_n", ni, 4);

        // Lanes 0..7 zero, 8..15 = 0x00FF
        zb = {{8{16'h00FF}}, {8{16'h0000}}};
        send(zb, 1'b1);
        wait_issue("t4");
        check("t4_zl", zero_lanes, 5'd8);
        check("t4_inputs", inputs, zb);
        step();
        check("t4_done", done, 1'b1);
        step();

        // 20 random bricks with valid held: back-pressure without loss or duplication
        base = issued_count;
        tx_q.delete();
        for (int i = 0; i < 20; i++) begin
            for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
            r[0] = 1'b1;
            tx_q.push_back(r);
        end
        exp_q = tx_q;
        run_stream("t5", ni, nd, nf);
        check("t5_n_issue", ni, 20);
        check("t5_n_done", nd, 1);
        check("t5_backpressure", (nf > 0), 1'b1);
        check("t5_count", issued_count, base + 16'd20);

        // B0, all-zero, B2 with last
        base = issued_count;
        tx_q = '{BW'(1), BW'(0), BW'(3)};
`ifdef ZERO_SKIP_EN
        exp_q = '{BW'(1), BW'(3)};
`else
        exp_q = '{BW'(1), BW'(0), BW'(3)};
`endif
        run_stream("t6", ni, nd, nf);
        check("t6_n_issue", ni, exp_q.size());
        check("t6_n_done", nd, 1);
        check("t6_count", issued_count, base + 16'(exp_q.size()));

        // Reset mid-fill discards the window
        send(BW'(16'h55), 1'b0);
        send(BW'(16'h66), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t7_rst_ready", ready, 1'b1);
        check("t7_rst_count", issued_count, 16'd0);
        check("t7_rst_zl", zero_lanes, 5'd16);
        check("t7_rst_sel", sel, 2'b11);
        @(posedge clk); #1;
        check("t7_rst_done", done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step();
        tx_q = '{BW'(16'h77)};
        exp_q = '{BW'(16'h77)};
        run_stream("t7", ni, nd, nf);
        check("t7_n_issue", ni, 1);
        check("t7_count", issued_count, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
